mbist_march_ctrl: RTL and testbench

- March C- sequencer for the MBIST path; sits directly upstream of the normal/BIST address-data multiplexer.
- Drives NbarT, which selects the BIST side, and supplies the BIST address, write data and read/write strobes.
- Compares memory read data against expected data and reports pass/fail and completion.
- Target memory has a synchronous read with 1-cycle latency.

---
 rtl/mbist_march_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST sequencer: drives the BIST side of the memory mux and checks read data.
// Optional MBIST_FAIL_LOG_EN adds fail_addr/fail_elem capture of the first mismatch.
module mbist_march_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  NbarT,
  output logic [ADDR_WIDTH-1:0] bist_addr,
  output logic [DATA_WIDTH-1:0] bist_wdata,
  output logic                  bist_we,
  output logic                  bist_re,
  output logic                  done,
  output logic                  fail
`ifdef MBIST_FAIL_LOG_EN
  ,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};

  state_t                r_state;
  logic [2:0]            r_elem;
  logic                  r_phase;
  logic [DATA_WIDTH-1:0] r_exp;
  logic                  r_cmp_v;
  logic [DATA_WIDTH-1:0] r_cmp_exp;

  state_t                w_state_next;
  logic [2:0]            w_elem_next;
  logic                  w_phase_next;
  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic                  w_nbart_next;
  logic                  w_done_next;
  logic                  w_re_next;
  logic                  w_we_next;
  logic [DATA_WIDTH-1:0] w_wdata_next;
  logic [DATA_WIDTH-1:0] w_exp_next;
  logic                  w_last_phase;
  logic                  w_addr_end;
  logic                  w_start_run;
  logic                  w_mismatch;

  assign w_start_run = (r_state == S_IDLE) && start;
  // Read data for the op issued two edges ago is on mem_rdata now.
  assign w_mismatch  = r_cmp_v && (mem_rdata != r_cmp_exp);

  always_comb begin
    w_state_next = r_state;
    w_elem_next  = r_elem;
    w_phase_next = r_phase;
    w_addr_next  = bist_addr;
    w_nbart_next = NbarT;
    w_done_next  = done;
    w_last_phase = (r_elem == 3'd0) || (r_elem == 3'd5) || r_phase;
    w_addr_end   = (r_elem < 3'd3) ? (bist_addr == ADDR_MAX) : (bist_addr == '0);

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_RUN;
          w_elem_next  = 3'd0;
          w_phase_next = 1'b0;
          w_addr_next  = '0;
          w_nbart_next = 1'b1;
          w_done_next  = 1'b0;
        end
      end
      S_RUN: begin
        if (!w_last_phase) begin
          w_phase_next = 1'b1;
        end else begin
          w_phase_next = 1'b0;
          if (!w_addr_end) begin
            w_addr_next = (r_elem < 3'd3) ? bist_addr + 1'b1 : bist_addr - 1'b1;
          end else if (r_elem == 3'd5) begin
            w_state_next = S_FLUSH;
          end else begin
            w_elem_next = r_elem + 3'd1;
            w_addr_next = (r_elem < 3'd2) ? '0 : ADDR_MAX;
          end
        end
      end
      S_FLUSH: begin
        w_state_next = S_DONE;
        w_done_next  = 1'b1;
      end
      S_DONE: begin
        if (!start) begin
          w_state_next = S_IDLE;
          w_nbart_next = 1'b0;
          w_done_next  = 1'b0;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    // First op of M1..M5 is a read; odd elements read 0s and write 1s, even the reverse.
    w_re_next    = (w_state_next == S_RUN) && (w_elem_next != 3'd0) && !w_phase_next;
    w_we_next    = (w_state_next == S_RUN) && !w_re_next;
    w_wdata_next = w_we_next ? {DATA_WIDTH{w_elem_next[0]}} : '0;
    w_exp_next   = {DATA_WIDTH{~w_elem_next[0]}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_elem     <= 3'd0;
      r_phase    <= 1'b0;
      r_exp      <= '0;
      r_cmp_v    <= 1'b0;
      r_cmp_exp  <= '0;
      NbarT      <= 1'b0;
      bist_addr  <= '0;
      bist_wdata <= '0;
      bist_we    <= 1'b0;
      bist_re    <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_elem     <= w_elem_next;
      r_phase    <= w_phase_next;
      r_exp      <= w_exp_next;
      r_cmp_v    <= bist_re;
      r_cmp_exp  <= r_exp;
      NbarT      <= w_nbart_next;
      bist_addr  <= w_addr_next;
      bist_wdata <= w_wdata_next;
      bist_we    <= w_we_next;
      bist_re    <= w_re_next;
      done       <= w_done_next;
      if (w_start_run) begin
        fail <= 1'b0;
      end else if (w_mismatch) begin
        fail <= 1'b1;
      end
    end
  end

`ifdef MBIST_FAIL_LOG_EN
  logic [ADDR_WIDTH-1:0] r_cmp_addr;
  logic [2:0]            r_cmp_elem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmp_addr <= '0;
      r_cmp_elem <= 3'd0;
      fail_addr  <= '0;
      fail_elem  <= 3'd0;
    end else begin
      r_cmp_addr <= bist_addr;
      r_cmp_elem <= r_elem;
      if (w_start_run) begin
        fail_addr <= '0;
        fail_elem <= 3'd0;
      end else if (w_mismatch && !fail) begin
        fail_addr <= r_cmp_addr;
        fail_elem <= r_cmp_elem;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Scoreboard bench for mbist_march_ctrl (N=4, 8-bit words) with a 1-cycle-latency memory model.
module tb_mbist_march_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  logic       NbarT;
  logic [1:0] bist_addr;
  logic [7:0] bist_wdata;
  logic       bist_we;
  logic       bist_re;
  logic       done;
  logic       fail;
`ifdef MBIST_FAIL_LOG_EN
  logic [1:0] fail_addr;
  logic [2:0] fail_elem;
`endif

  mbist_march_ctrl #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_rdata(mem_rdata),
    .NbarT(NbarT), .bist_addr(bist_addr), .bist_wdata(bist_wdata),
    .bist_we(bist_we), .bist_re(bist_re), .done(done), .fail(fail)
`ifdef MBIST_FAIL_LOG_EN
    , .fail_addr(fail_addr), .fail_elem(fail_elem)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] mem [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  bit         fault_en = 1'b0;

  // Bit 3 of word 2 stuck at 0 when the fault is enabled.
  always @(posedge clk) begin
    if (NbarT && bist_we) mem[bist_addr] <= bist_wdata;
    if (NbarT && bist_re)
      mem_rdata <= (fault_en && bist_addr == 2'd2) ? (mem[bist_addr] & 8'hF7) : mem[bist_addr];
  end

  typedef struct {
    bit         is_done;
    int         idx;
    bit         we;
    bit         re;
    logic [1:0] addr;
    logic [7:0] wdata;
    bit         fl;
  } rec_t;

  rec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // March C-: direction, op count, and per-op kind (1=read) / data value.
  int el_down [6] = '{0, 0, 0, 1, 1, 1};
  int el_nops [6] = '{1, 2, 2, 2, 2, 1};
  int el_rd0  [6] = '{0, 1, 1, 1, 1, 1};
  int el_val0 [6] = '{0, 0, 1, 0, 1, 0};
  int el_val1 [6] = '{0, 1, 0, 1, 0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_run(input bit exp_fail);
    rec_t r;
    int   k = 0;
    for (int e = 0; e < 6; e++) begin
      for (int a = 0; a < 4; a++) begin
        for (int p = 0; p < el_nops[e]; p++) begin
          r.is_done = 1'b0;
          r.idx     = k;
          r.re      = (p == 0) && (el_rd0[e] != 0);
          r.we      = !r.re;
          r.addr    = 2'(el_down[e] != 0 ? 3 - a : a);
          r.wdata   = r.re ? 8'h00 : (((p == 0 ? el_val0[e] : el_val1[e]) != 0) ? 8'hFF : 8'h00);
          r.fl      = 1'b0;
          sb.push_back(r);
          k++;
        end
      end
    end
    r.is_done = 1'b1;
    r.idx     = 41;
    r.we      = 1'b0;
    r.re      = 1'b0;
    r.addr    = 2'd0;
    r.wdata   = 8'h00;
    r.fl      = exp_fail;
    sb.push_back(r);
  endtask

  int   ncyc = 0;
  int   base = 0;
  logic done_q = 1'b0;
  rec_t mr;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bist_we || bist_re) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_op actual we=%0b re=%0b addr=%0d required none", bist_we, bist_re, bist_addr);
        end else begin
          mr = sb.pop_front();
          if (!mr.is_done && mr.idx == 0) base = ncyc;
          if (mr.is_done || !NbarT || bist_we !== mr.we || bist_re !== mr.re ||
              bist_addr !== mr.addr || bist_wdata !== mr.wdata || (ncyc - base) != mr.idx) begin
            errors++;
            $display("FAIL op%0d actual nbart=%0b we=%0b re=%0b addr=%0d wdata=%h cyc=%0d required nbart=1 we=%0b re=%0b addr=%0d wdata=%h cyc=%0d",
                     mr.idx, NbarT, bist_we, bist_re, bist_addr, bist_wdata, ncyc - base,
                     mr.we, mr.re, mr.addr, mr.wdata, mr.idx);
          end else begin
            $display("op%0d we=%0b re=%0b addr=%0d wdata=%h", mr.idx, bist_we, bist_re, bist_addr, bist_wdata);
          end
        end
      end
      if (done && !done_q) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done actual done=1 required none");
        end else begin
          mr = sb.pop_front();
          if (!mr.is_done || !NbarT || fail !== mr.fl || (ncyc - base) != mr.idx) begin
            errors++;
            $display("FAIL done actual nbart=%0b fail=%0b cyc=%0d required nbart=1 fail=%0b cyc=%0d",
                     NbarT, fail, ncyc - base, mr.fl, mr.idx);
          end else begin
            $display("done fail=%0b cyc=%0d", fail, ncyc - base);
          end
        end
      end
    end
    done_q = done;
    ncyc++;
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_nbart"}, 32'(NbarT), 0);
    chk({tag, "_addr"},  32'(bist_addr), 0);
    chk({tag, "_wdata"}, 32'(bist_wdata), 0);
    chk({tag, "_we"},    32'(bist_we), 0);
    chk({tag, "_re"},    32'(bist_re), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_fail"},  32'(fail), 0);
`ifdef MBIST_FAIL_LOG_EN
    chk({tag, "_faddr"}, 32'(fail_addr), 0);
    chk({tag, "_felem"}, 32'(fail_elem), 0);
`endif
  endtask

  task automatic do_run(input bit fault, input bit pulse, input int hold, input int abort_at);
    int cnt;
    fault_en = fault;
    push_run(fault);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (hold == 0) start = 1'b0;
    chk("fail_clear_on_start", 32'(fail), 0);
    chk("nbart_on_start", 32'(NbarT), 1);
    if (abort_at > 0) begin
      repeat (abort_at) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk_all_zero("midrun_rst");
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end
    if (pulse) begin
      repeat (10) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    cnt = 0;
    while (!done && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("done_seen", 32'(done), 1);
`ifdef MBIST_FAIL_LOG_EN
    chk("fail_addr", 32'(fail_addr), fault ? 2 : 0);
    chk("fail_elem", 32'(fail_elem), fault ? 2 : 0);
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_done", 32'(done), 1);
      chk("hold_nbart", 32'(NbarT), 1);
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_nbart", 32'(NbarT), 0);
    chk("idle_done", 32'(done), 0);
  endtask

  initial begin
    int cnt;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    do_run(1'b0, 1'b0, 0, 0);
    chk("run1_fail", 32'(fail), 0);
    do_run(1'b0, 1'b0, 0, 15);
    do_run(1'b0, 1'b0, 0, 0);
    chk("after_rst_fail", 32'(fail), 0);
    do_run(1'b1, 1'b0, 5, 0);
    chk("fail_sticky_idle", 32'(fail), 1);
    do_run(1'b0, 1'b1, 0, 0);
    chk("pulse_run_fail", 32'(fail), 0);

    cnt = 0;
    while (sb.size() != 0 && cnt < 50) begin
      @(posedge clk);
      cnt++;
    end
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
